// File: rtl/mem_clear_arbiter.sv
// mem_clear_arbiter: zero-fill sequencer plus round-robin A/B port arbiter; optional readback check under `MEMCLR_VERIFY_EN
`timescale 1ns/1ps
module mem_clear_arbiter #(
    parameter int SIZE = 16,
    parameter int AW   = 4,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    output logic          done,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          verify_err
);
    localparam int IW = AW + 1;
    localparam logic [IW-1:0] ONE  = IW'(1);
    localparam logic [IW-1:0] LAST = IW'(SIZE - 1);
`ifdef MEMCLR_VERIFY_EN
    localparam logic [IW-1:0] VEND = IW'(SIZE);
`endif
    typedef enum logic [1:0] {CLEAR = 2'd0, VERIFY = 2'd1, SERVE = 2'd2} state_t;
    state_t        r_state, w_state_nx;
    logic [IW-1:0] r_idx, w_idx_nx;
    logic          r_rr, w_rr_nx, r_err, w_err_nx, r_first, w_first_nx;
    logic          w_a_gnt, w_b_gnt, w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    // state, pass counter, round-robin pointer, sticky error and done flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_idx   <= '0;
            r_rr    <= 1'b0;
            r_err   <= 1'b0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_rr    <= w_rr_nx;
            r_err   <= w_err_nx;
            r_first <= w_first_nx;
        end
    end
    // next-state, arbitration and memory port mux
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_rr_nx    = r_rr;
        w_err_nx   = r_err;
        w_a_gnt    = 1'b0;
        w_b_gnt    = 1'b0;
        w_we       = 1'b0;
        w_addr     = '0;
        w_wdata    = '0;
        case (r_state)
            CLEAR: begin
                w_we     = 1'b1;
                w_addr   = r_idx[AW-1:0];
                w_idx_nx = r_idx + ONE;
                if (r_idx == LAST) begin
                    w_idx_nx = '0;
`ifdef MEMCLR_VERIFY_EN
                    w_state_nx = VERIFY;
`else
                    w_state_nx = SERVE;
`endif
                end
            end
`ifdef MEMCLR_VERIFY_EN
            VERIFY: begin
                w_addr   = (r_idx < VEND) ? r_idx[AW-1:0] : '0;
                w_idx_nx = r_idx + ONE;
                if (r_idx != '0 && mem_rdata != '0) w_err_nx = 1'b1;
                if (r_idx == VEND) begin
                    w_idx_nx   = '0;
                    w_state_nx = SERVE;
                end
            end
`endif
            SERVE: begin
                if (clr_req) begin
                    w_state_nx = CLEAR;
                    w_idx_nx   = '0;
                    w_err_nx   = 1'b0;
                end else begin
                    w_a_gnt = a_req & (~b_req | ~r_rr);
                    w_b_gnt = b_req & ~w_a_gnt;
                    if (w_a_gnt) begin
                        w_we    = a_we;
                        w_addr  = a_addr;
                        w_wdata = a_wdata;
                        w_rr_nx = 1'b1;
                    end else if (w_b_gnt) begin
                        w_we    = b_we;
                        w_addr  = b_addr;
                        w_wdata = b_wdata;
                        w_rr_nx = 1'b0;
                    end
                end
            end
            default: w_state_nx = CLEAR;
        endcase
        w_first_nx = (w_state_nx == SERVE) && (r_state != SERVE);
    end
    assign busy      = ~rst & (r_state != SERVE);
    assign done      = ~rst & r_first;
    assign a_gnt     = ~rst & w_a_gnt;
    assign b_gnt     = ~rst & w_b_gnt;
    assign mem_we    = ~rst & w_we;
    assign mem_addr  = rst ? '0 : w_addr;
    assign mem_wdata = rst ? '0 : w_wdata;
`ifdef MEMCLR_VERIFY_EN
    assign verify_err = ~rst & r_err;
`else
    logic w_unused;
    assign w_unused   = ^{mem_rdata, r_err};
    assign verify_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_clear_arbiter.sv
// tb_mem_clear_arbiter: scoreboard bench for mem_clear_arbiter; handles `MEMCLR_VERIFY_EN builds too
`timescale 1ns/1ps
module tb_mem_clear_arbiter;
    localparam int SIZE = 16;
`ifdef MEMCLR_VERIFY_EN
    localparam bit VER  = 1'b1;
    localparam int PASS = 2 * SIZE + 1;
`else
    localparam bit VER  = 1'b0;
    localparam int PASS = SIZE;
`endif
    typedef struct packed {
        logic       a_gnt;
        logic       b_gnt;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       done;
        logic       busy;
    } ev_t;

    logic       clk = 1'b0, rst = 1'b1, clr_req = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [3:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;
    logic       busy, done, a_gnt, b_gnt, mem_we, verify_err;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic [7:0] mem [SIZE];
    logic       bad = 1'b0;
    ev_t        q [$];
    int         n_cmp = 0, n_bad = 0;

    mem_clear_arbiter #(.SIZE(SIZE), .AW(4), .DW(8)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy), .done(done),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    // memory macro model; bad forces address 9 to read back 8'h01
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= (bad && mem_addr == 4'd9) ? 8'h01 : mem[mem_addr];
    end

    // monitor: every write, grant or done pulse pops one expected event
    always @(negedge clk) begin
        if (!rst && (mem_we || a_gnt || b_gnt || done)) begin
            ev_t obs, exp_e;
            obs = '{a_gnt, b_gnt, mem_we, mem_addr, mem_wdata, done, busy};
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL event: got %h with nothing expected (fields a,b,we,addr,wdata,done,busy)", obs);
            end else begin
                exp_e = q.pop_front();
                if (obs !== exp_e) begin
                    n_bad++;
                    $display("FAIL event @%0t: got %h expected %h (fields a,b,we,addr,wdata,done,busy)", $time, obs, exp_e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic ev_t ev(input logic a, input logic b, input logic we, input logic [3:0] ad,
                               input logic [7:0] wd, input logic dn, input logic bs);
        ev = '{a, b, we, ad, wd, dn, bs};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear(input int n);
        for (int i = 0; i < n; i++) q.push_back(ev(1'b0, 1'b0, 1'b1, 4'(i), 8'h00, 1'b0, 1'b1));
    endtask

    task automatic run_pass(input logic bad_exp);
        for (int k = 0; k < PASS; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy_start", 32'(busy), 32'd1);
            chk("verify_err_pass", 32'(verify_err), 32'((VER && k >= SIZE + 11) ? bad_exp : 1'b0));
            tick();
        end
    endtask

    initial begin
        tick();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_err", 32'(verify_err), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        push_clear(SIZE);
        run_pass(1'b0);
        q.push_back(ev(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0));
        @(negedge clk);
        chk("serve_busy", 32'(busy), 32'd0);
        tick();
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 8'h5A;
        q.push_back(ev(1'b1, 1'b0, 1'b1, 4'd3, 8'h5A, 1'b0, 1'b0));
        tick();
        a_req = 1'b0; b_req = 1'b1; b_we = 1'b1; b_addr = 4'd5; b_wdata = 8'h33;
        q.push_back(ev(1'b0, 1'b1, 1'b1, 4'd5, 8'h33, 1'b0, 1'b0));
        tick();
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd2; a_wdata = 8'h11;
        b_addr = 4'd7; b_wdata = 8'h77;
        for (int i = 0; i < 2; i++) begin
            q.push_back(ev(1'b1, 1'b0, 1'b0, 4'd2, 8'h11, 1'b0, 1'b0));
            tick();
            q.push_back(ev(1'b0, 1'b1, 1'b1, 4'd7, 8'h77, 1'b0, 1'b0));
            tick();
        end
        a_req = 1'b0;
        q.push_back(ev(1'b0, 1'b1, 1'b1, 4'd7, 8'h77, 1'b0, 1'b0));
        tick();
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd4; a_wdata = 8'h44;
        clr_req = 1'b1; bad = 1'b1;
        @(negedge clk);
        chk("clr_no_gnt", 32'(a_gnt), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        tick();
        clr_req = 1'b0;
        push_clear(SIZE);
        run_pass(1'b1);
        q.push_back(ev(1'b1, 1'b0, 1'b1, 4'd4, 8'h44, 1'b1, 1'b0));
        @(negedge clk);
        chk("err_after_bad", 32'(verify_err), 32'(VER));
        tick();
        a_req = 1'b0; bad = 1'b0; clr_req = 1'b1;
        @(negedge clk);
        chk("err_sticky", 32'(verify_err), 32'(VER));
        tick();
        clr_req = 1'b0;
        push_clear(SIZE);
        run_pass(1'b0);
        q.push_back(ev(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0));
        @(negedge clk);
        chk("err_clean", 32'(verify_err), 32'd0);
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        push_clear(7);
        repeat (7) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_we", 32'(mem_we), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        push_clear(SIZE);
        run_pass(1'b0);
        q.push_back(ev(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0));
        tick();
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; a_addr = 4'd1; a_wdata = 8'h00;
        q.push_back(ev(1'b1, 1'b0, 1'b0, 4'd1, 8'h00, 1'b0, 1'b0));
        tick();
        a_req = 1'b0; b_req = 1'b0;
        tick();
        tick();
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
